// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared types and divider helper for the LED celebration engine
package led_pkg;

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        SCROLL = 2'd1,
        BOUNCE = 2'd2,
        BLINK  = 2'd3
    } led_mode_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } led_state_e;

    function automatic int calc_div(int clk_hz, int step_hz);
        return clk_hz / step_hz;
    endfunction

endpackage

// File: rtl/led_pattern_engine_if.sv
// rtl/led_pattern_engine_if.sv - run request, pattern select and LED outputs of the engine
interface led_pattern_engine_if #(
    parameter int N_LEDS = 16
) ();
    logic              game_over;
    logic [1:0]        mode;
    logic [N_LEDS-1:0] led;
    logic              cycle_done;

    modport master (output game_over, output mode, input led, input cycle_done);
    modport slave  (input game_over, input mode, output led, output cycle_done);
endinterface

// File: rtl/step_divider.sv
// rtl/step_divider.sv - prescaler producing one tick every DIV cycles, held at zero by clr
module step_divider #(
    parameter int DIV = 1
) (
    input  logic clk_fpga,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick = !clr && (cnt_q == CW'(DIV - 1));

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_fpga) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/led_pattern_engine.sv
// rtl/led_pattern_engine.sv - end-of-game LED pattern engine; BOUNCE pattern built only with LED_BOUNCE_EN
module led_pattern_engine
    import led_pkg::*;
#(
    parameter int N_LEDS  = 16,
    parameter int CLK_HZ  = 100_000_000,
    parameter int STEP_HZ = 10
) (
    input  logic                 clk_fpga,
    input  logic                 rst_n,
    led_pattern_engine_if.slave  io
);
    localparam int DIV = calc_div(CLK_HZ, STEP_HZ);
    localparam int PW  = $clog2(N_LEDS);

    typedef logic [PW-1:0] pos_t;
    localparam pos_t LAST = pos_t'(N_LEDS - 1);

    led_state_e        state_q, state_d;
    led_mode_e         mode_q, mode_d;
    pos_t              pos_q, pos_d;
    logic [N_LEDS-1:0] led_q, led_d;
    logic              done_q, done_d;
    logic              tick;
`ifdef LED_BOUNCE_EN
    logic              dir_q, dir_d;  // 0 = rising, 1 = falling
`endif

    step_divider #(.DIV(DIV)) u_div (
        .clk_fpga (clk_fpga),
        .rst_n    (rst_n),
        .clr      (state_q == IDLE),
        .tick     (tick)
    );

    function automatic logic [N_LEDS-1:0] frame(led_mode_e m, pos_t p);
        logic [N_LEDS-1:0] f;
        for (int i = 0; i < N_LEDS; i++) begin
            case (m)
                FILL:    f[i] = (i <= int'(p));
                BLINK:   f[i] = (p == '0);
                default: f[i] = (i == int'(p));
            endcase
        end
        return f;
    endfunction

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        pos_d   = pos_q;
        led_d   = led_q;
        done_d  = 1'b0;
`ifdef LED_BOUNCE_EN
        dir_d   = dir_q;
`endif
        case (state_q)
            IDLE: begin
                led_d = '0;
                pos_d = '0;
`ifdef LED_BOUNCE_EN
                dir_d = 1'b0;
`endif
                if (io.game_over) begin
                    state_d = RUN;
                    mode_d  = led_mode_e'(io.mode);
                    led_d   = frame(mode_d, '0);
                end
            end
            default: begin
                // Dropping game_over wins over a coincident tick.
                if (!io.game_over) begin
                    state_d = IDLE;
                    led_d   = '0;
                    pos_d   = '0;
`ifdef LED_BOUNCE_EN
                    dir_d   = 1'b0;
`endif
                end else if (tick) begin
                    case (mode_q)
                        BLINK:   pos_d = (pos_q == '0) ? pos_t'(1) : '0;
`ifdef LED_BOUNCE_EN
                        BOUNCE: begin
                            pos_d = dir_q ? pos_q - 1'b1 : pos_q + 1'b1;
                            dir_d = (pos_d == LAST) ? 1'b1 : ((pos_d == '0) ? 1'b0 : dir_q);
                        end
`endif
                        default: pos_d = (pos_q == LAST) ? '0 : pos_q + 1'b1;
                    endcase
                    led_d  = frame(mode_q, pos_d);
                    done_d = (pos_d == '0);
                end
            end
        endcase
    end

    always_ff @(posedge clk_fpga) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mode_q  <= FILL;
            pos_q   <= '0;
            led_q   <= '0;
            done_q  <= 1'b0;
`ifdef LED_BOUNCE_EN
            dir_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            pos_q   <= pos_d;
            led_q   <= led_d;
            done_q  <= done_d;
`ifdef LED_BOUNCE_EN
            dir_q   <= dir_d;
`endif
        end
    end

    assign io.led        = led_q;
    assign io.cycle_done = done_q;
endmodule

// File: tb/tb_led_pattern_engine.sv
// tb/tb_led_pattern_engine.sv - random-stimulus bench for led_pattern_engine at DIV=4 and DIV=1
module tb_led_pattern_engine;
    logic       clk;
    logic       rst_n;
    logic       game_over;
    logic [1:0] mode;

    int n_tests = 0;
    int n_fail  = 0;

    led_pattern_engine_if #(.N_LEDS(8)) bus4 ();
    led_pattern_engine_if #(.N_LEDS(8)) bus1 ();

    assign bus4.game_over = game_over;
    assign bus4.mode      = mode;
    assign bus1.game_over = game_over;
    assign bus1.mode      = mode;

    led_pattern_engine #(.N_LEDS(8), .CLK_HZ(40), .STEP_HZ(10)) u_dut4 (
        .clk_fpga (clk),
        .rst_n    (rst_n),
        .io       (bus4)
    );

    led_pattern_engine #(.N_LEDS(8), .CLK_HZ(40), .STEP_HZ(40)) u_dut1 (
        .clk_fpga (clk),
        .rst_n    (rst_n),
        .io       (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: per instance, whether running, latched mode, and cycles elapsed since start edge.
    int run_m [2];
    int mode_m[2];
    int t_m   [2];

    function automatic int div_of(int i);
        return (i == 0) ? 4 : 1;
    endfunction

    function automatic int period(int m);
        int p;
        case (m)
            3:       p = 2;
`ifdef LED_BOUNCE_EN
            2:       p = 14;
`endif
            default: p = 8;
        endcase
        return p;
    endfunction

    function automatic logic [7:0] exp_frame(int m, int f);
        logic [7:0] v;
        int p;
        case (m)
            0: v = 8'((1 << (f + 1)) - 1);
            3: v = (f % 2 == 0) ? 8'hFF : 8'h00;
            default: begin
                p = f;
`ifdef LED_BOUNCE_EN
                if (m == 2 && f >= 8) p = 14 - f;
`endif
                v = 8'(1 << p);
            end
        endcase
        return v;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                run_m[i] = 0;
            end else if (run_m[i] == 0) begin
                if (game_over) begin
                    run_m[i]  = 1;
                    mode_m[i] = int'(mode);
                    t_m[i]    = 0;
                end
            end else if (!game_over) begin
                run_m[i] = 0;
            end else begin
                t_m[i]++;
            end
        end
    endtask

    task automatic compare();
        logic [7:0] e_led;
        logic       e_done;
        int f;
        for (int i = 0; i < 2; i++) begin
            e_led  = 8'h00;
            e_done = 1'b0;
            if (run_m[i] != 0) begin
                f      = (t_m[i] / div_of(i)) % period(mode_m[i]);
                e_led  = exp_frame(mode_m[i], f);
                e_done = (t_m[i] > 0) && (t_m[i] % div_of(i) == 0) && (f == 0);
            end
            if (i == 0) begin
                check("led_div4", 32'(bus4.led), 32'(e_led));
                check("done_div4", 32'(bus4.cycle_done), 32'(e_done));
            end else begin
                check("led_div1", 32'(bus1.led), 32'(e_led));
                check("done_div1", 32'(bus1.cycle_done), 32'(e_done));
            end
        end
    endtask

    task automatic cycle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            compare();
        end
    endtask

    initial begin
        int len;
        for (int i = 0; i < 2; i++) begin
            run_m[i]  = 0;
            mode_m[i] = 0;
            t_m[i]    = 0;
        end
        rst_n     = 1'b0;
        game_over = 1'b0;
        mode      = 2'd0;
        cycle(3);
        rst_n = 1'b1;
        cycle(2);

        // Directed FILL pass covering a full period plus wrap.
        game_over = 1'b1;
        mode      = 2'd0;
        cycle(40);
        game_over = 1'b0;
        cycle(3);

        // Directed BLINK with a mid-run mode change.
        mode      = 2'd3;
        game_over = 1'b1;
        cycle(10);
        mode = 2'd1;
        cycle(20);
        game_over = 1'b0;
        cycle(1);
        game_over = 1'b1;
        cycle(20);
        game_over = 1'b0;
        cycle(2);

        for (int ep = 0; ep < 60; ep++) begin
            mode      = 2'($urandom % 4);
            game_over = 1'b1;
            len       = int'($urandom_range(5, 120));
            for (int c = 0; c < len; c++) begin
                if ($urandom % 10 == 0) mode = 2'($urandom % 4);
                rst_n = ($urandom % 150 == 0) ? 1'b0 : 1'b1;
                cycle(1);
            end
            rst_n     = 1'b1;
            game_over = 1'b0;
            cycle(int'($urandom_range(1, 4)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
